// File: rtl/mmio_peripheral_pkg.sv
// ============================================================================
// Module      : mmio_peripheral_pkg
// Description : Register map, TCON bit positions and default window base
//               shared by the MMIO peripheral and the CPU read mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_peripheral_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

    // Register indices as seen on Address[4:2] (byte offset / 4)
    localparam logic [2:0] MMIO_TH      = 3'd0;
    localparam logic [2:0] MMIO_TL      = 3'd1;
    localparam logic [2:0] MMIO_TCON    = 3'd2;
    localparam logic [2:0] MMIO_LED     = 3'd3;
    localparam logic [2:0] MMIO_DIGITS  = 3'd4;
    localparam logic [2:0] MMIO_SYSTICK = 3'd5;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module      : mmio_timer
// Description : Reloadable up-counting timer with prescaler, status and irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_peripheral_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        we_th,
    input  logic        we_tl,
    input  logic        we_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    localparam int unsigned      PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    C_PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic [31:0]   r_th;
    logic [31:0]   r_tl;
    logic [2:0]    r_tcon;

    logic w_tick;
    logic w_ovf;
    logic w_reload;

    assign w_tick   = r_tcon[TCON_EN] && (r_pcnt == C_PMAX);
    assign w_ovf    = w_tick && (r_tl == 32'hFFFF_FFFF);
    // A simultaneous TL store suppresses both the reload and the status event
    assign w_reload = w_ovf && !we_tl;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pcnt <= '0;
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (we_tcon)
                r_pcnt <= '0;
            else if (r_tcon[TCON_EN])
                r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);

            if (we_th)
                r_th <= wdata;

            if (we_tl)
                r_tl <= wdata;
            else if (w_tick)
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;

            // Status written by software is OR-ed with a same-cycle overflow so no irq is lost
            if (we_tcon)
                r_tcon <= {wdata[TCON_ST] | (w_reload & wdata[TCON_IE]),
                           wdata[TCON_IE], wdata[TCON_EN]};
            else if (w_reload && r_tcon[TCON_IE])
                r_tcon[TCON_ST] <= 1'b1;
        end
    end

    assign th   = r_th;
    assign tl   = r_tl;
    assign tcon = r_tcon;
    assign irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule

`default_nettype wire

// File: rtl/mmio_peripheral.sv
// ============================================================================
// Module      : mmio_peripheral
// Description : MMIO responder: address decode, LED/DIGITS/SYSTICK, read mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_peripheral
    import mmio_peripheral_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [31:0] BASE     = MMIO_BASE_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [7:0]  led,
    output logic [15:0] digits,
    output logic        irq
);

    logic [2:0]  w_idx;
    logic        w_hit;
    logic        w_store;
    logic [31:0] w_th;
    logic [31:0] w_tl;
    logic [2:0]  w_tcon;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [7:0]  r_led;
    logic [15:0] r_digits;
    logic [31:0] r_systick;

    assign w_idx    = Address[4:2];
    assign w_hit    = (Address[31:5] == BASE[31:5]) && (w_idx <= MMIO_SYSTICK);
    assign w_store  = MemWrite && w_hit;
    // Read data is driven whenever the address hits, so MemRead is not needed
    assign w_unused = &{1'b0, MemRead, Address[1:0]};

    mmio_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .we_th   (w_store && (w_idx == MMIO_TH)),
        .we_tl   (w_store && (w_idx == MMIO_TL)),
        .we_tcon (w_store && (w_idx == MMIO_TCON)),
        .wdata   (Write_data),
        .th      (w_th),
        .tl      (w_tl),
        .tcon    (w_tcon),
        .irq     (irq)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_led     <= '0;
            r_digits  <= '0;
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
            if (w_store && (w_idx == MMIO_LED))
                r_led <= Write_data[7:0];
            if (w_store && (w_idx == MMIO_DIGITS))
                r_digits <= Write_data[15:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_idx)
                MMIO_TH:      w_rdata = w_th;
                MMIO_TL:      w_rdata = w_tl;
                MMIO_TCON:    w_rdata = {29'd0, w_tcon};
                MMIO_LED:     w_rdata = {24'd0, r_led};
                MMIO_DIGITS:  w_rdata = {16'd0, r_digits};
                MMIO_SYSTICK: w_rdata = r_systick;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign Read_data = w_rdata;
    assign led       = r_led;
    assign digits    = r_digits;

endmodule

`default_nettype wire
